// File: rtl/reg_dump_reader_pkg.sv
// Shared definitions for the register-file debug dump reader.
// Default widths match the CPU register file.
package reg_dump_reader_pkg;

    localparam int unsigned RF_ADDR_W = 5;
    localparam int unsigned RF_DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/reg_dump_reader.sv
// Walks the register file debug read port from FIRST_ADDR to LAST_ADDR.
// Each {addr,data} snapshot is streamed out over a valid/ready handshake.
module reg_dump_reader
    import reg_dump_reader_pkg::*;
#(
    parameter int unsigned ADDR_W     = RF_ADDR_W,
    parameter int unsigned DATA_W     = RF_DATA_W,
    parameter int unsigned FIRST_ADDR = 0,
    parameter int unsigned LAST_ADDR  = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_ADDR);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_ADDR);

    state_e              state, state_nxt;
    logic [ADDR_W-1:0]   cnt_nxt;
    logic                valid_nxt;
    logic [ADDR_W-1:0]   oaddr_nxt;
    logic [DATA_W-1:0]   odata_nxt;
    logic                busy_nxt;
    logic                done_nxt;

    // Next-state and next-output decode; rd_addr doubles as the address counter.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = rd_addr;
        valid_nxt = out_valid;
        oaddr_nxt = out_addr;
        odata_nxt = out_data;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_READ;
                    cnt_nxt   = FIRST_A;
                end
            end
            S_READ: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = FIRST_A;
                    valid_nxt = 1'b0;
                end else begin
                    state_nxt = S_HOLD;
                    oaddr_nxt = rd_addr;
                    odata_nxt = rd_data;
                    valid_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                // Abort wins over a same-cycle handshake; the beat is dropped.
                if (abort) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = FIRST_A;
                    valid_nxt = 1'b0;
                end else if (out_ready) begin
                    valid_nxt = 1'b0;
                    if (rd_addr == LAST_A) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_READ;
                        cnt_nxt   = rd_addr + ADDR_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                cnt_nxt   = FIRST_A;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = FIRST_A;
                valid_nxt = 1'b0;
            end
        endcase

        busy_nxt = (state_nxt == S_READ) || (state_nxt == S_HOLD);
        done_nxt = (state_nxt == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            rd_addr   <= FIRST_A;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            rd_addr   <= cnt_nxt;
            out_valid <= valid_nxt;
            out_addr  <= oaddr_nxt;
            out_data  <= odata_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

endmodule
